// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch predictor resolve path.
package bp_pkg;

    localparam int BP_IDX_W = 8;
    localparam int BP_XLEN  = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } bru_state_e;

    typedef struct packed {
        logic [BP_XLEN-1:0] pc;
        logic               taken;
        logic [BP_XLEN-1:0] target;
    } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-flight prediction FIFO: holds predictions issued at IF until EX resolves them in order.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  bp_entry_t push_data,
    input  logic      pop,
    input  logic      clear,
    output bp_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    bp_entry_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks in-flight branch predictions against EX outcomes, redirects on mispredict, trains the predictor.
// Optional feature: define BRU_PERF_CNT_EN to add perf_resolved / perf_mispred counters.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = BP_IDX_W,
    parameter int XLEN  = BP_XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic [XLEN-1:0]  pred_pc,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_pc,
    input  logic             res_taken,
    input  logic [XLEN-1:0]  res_target,
    output logic             res_ready,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             upd_valid,
    output logic [IDX_W-1:0] upd_idx,
    output logic             upd_taken,
    input  logic             upd_ready,
    output logic             order_err
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]      perf_resolved,
    output logic [31:0]      perf_mispred
`endif
);

    bru_state_e      state;
    bru_state_e      next_state;
    bp_entry_t       push_entry;
    bp_entry_t       head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_clear;
    logic            in_idle;
    logic            upd_busy;
    logic            res_fire;
    logic            res_match;
    logic            res_accept;
    logic            res_error;
    logic            mispredict;
    logic [XLEN-1:0] correct_pc;

    assign push_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target};
    assign in_idle    = (state == IDLE);
    assign upd_busy   = upd_valid && !upd_ready;
    assign pred_ready = !fifo_full && in_idle;
    assign res_ready  = !upd_busy && in_idle;
    assign fifo_push  = pred_valid && pred_ready;

    // Only the oldest outstanding prediction may resolve; anything else is an ordering error.
    assign res_fire   = res_valid && res_ready;
    assign res_match  = !fifo_empty && (res_pc == head.pc);
    assign res_accept = res_fire && res_match;
    assign res_error  = res_fire && !res_match;
    assign mispredict = (head.taken != res_taken) || (res_taken && (head.target != res_target));
    assign correct_pc = res_taken ? res_target : (res_pc + XLEN'(4));

    bp_inflight_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (res_accept),
        .clear     (fifo_clear),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // The FLUSH cycle drops every younger entry since they were fetched down the wrong path.
    always_comb begin
        next_state     = state;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        fifo_clear     = 1'b0;
        case (state)
            IDLE: begin
                if (res_accept && mispredict) next_state = FLUSH;
            end
            FLUSH: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                fifo_clear     = 1'b1;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_pc <= '0;
            order_err   <= 1'b0;
        end else begin
            order_err <= res_error;
            if (res_accept && mispredict) redirect_pc <= correct_pc;
        end
    end

    // A new training write may load in the same cycle the previous one is taken by the predictor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_valid <= 1'b0;
            upd_idx   <= '0;
            upd_taken <= 1'b0;
        end else if (res_accept) begin
            upd_valid <= 1'b1;
            upd_idx   <= res_pc[IDX_W+1:2];
            upd_taken <= res_taken;
        end else if (upd_valid && upd_ready) begin
            upd_valid <= 1'b0;
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_resolved <= '0;
            perf_mispred  <= '0;
        end else if (res_accept) begin
            perf_resolved <= perf_resolved + 32'd1;
            if (mispredict) perf_mispred <= perf_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed cases followed by randomised traffic.
// Build with BRU_PERF_CNT_EN defined to also check the performance counters.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int IDX_W = 8;
    localparam int XLEN  = 32;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_t;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             pred_valid;
    logic [XLEN-1:0]  pred_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             pred_ready;
    logic             res_valid;
    logic [XLEN-1:0]  res_pc;
    logic             res_taken;
    logic [XLEN-1:0]  res_target;
    logic             res_ready;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_ready;
    logic             order_err;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]      perf_resolved;
    logic [31:0]      perf_mispred;
`endif

    branch_resolve_unit #(
        .DEPTH(DEPTH),
        .IDX_W(IDX_W),
        .XLEN (XLEN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_ready     (pred_ready),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .res_ready      (res_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .upd_taken      (upd_taken),
        .upd_ready      (upd_ready),
        .order_err      (order_err)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_resolved  (perf_resolved),
        .perf_mispred   (perf_mispred)
`endif
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    pred_t       model_q[$];
    upd_t        exp_upd[$];
    logic [31:0] exp_redir[$];
    bit          m_flush        = 1'b0;
    bit          m_upd_pend     = 1'b0;
    bit          m_err_pulse    = 1'b0;
    bit          exp_pred_ready = 1'b1;
    bit          exp_res_ready  = 1'b1;
    bit          mon_en         = 1'b0;
    int unsigned m_resolved     = 0;
    int unsigned m_mispred      = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, predicts the handshakes from the model, and commits at the edge.
    task automatic applyStimulus(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptgt,
                                 input logic rv, input logic [31:0] rpc, input logic rt, input logic [31:0] rtgt,
                                 input logic ur);
        bit    do_push;
        bit    do_accept;
        bit    do_err;
        pred_t e;
        upd_t  u;
        pred_valid  = pv;
        pred_pc     = ppc;
        pred_taken  = pt;
        pred_target = ptgt;
        res_valid   = rv;
        res_pc      = rpc;
        res_taken   = rt;
        res_target  = rtgt;
        upd_ready   = ur;
        exp_pred_ready = !m_flush && (model_q.size() < DEPTH);
        exp_res_ready  = !m_flush && !(m_upd_pend && !ur);
        do_push   = pv && exp_pred_ready;
        do_accept = 1'b0;
        do_err    = 1'b0;
        if (rv && exp_res_ready) begin
            if (model_q.size() > 0 && model_q[0].pc == rpc) do_accept = 1'b1;
            else                                             do_err    = 1'b1;
        end
        mon_en = 1'b1;
        @(posedge clk);
        m_err_pulse = do_err;
        if (m_flush) begin
            model_q.delete();
            m_flush = 1'b0;
        end
        if (m_upd_pend && ur) m_upd_pend = 1'b0;
        if (do_accept) begin
            e = model_q.pop_front();
            u.idx   = rpc[IDX_W+1:2];
            u.taken = rt;
            exp_upd.push_back(u);
            m_upd_pend = 1'b1;
            m_resolved++;
            if ((e.taken != rt) || (rt && (e.target != rtgt))) begin
                exp_redir.push_back(rt ? rtgt : rpc + 32'd4);
                m_flush = 1'b1;
                m_mispred++;
            end
        end
        if (do_push) begin
            e.pc     = ppc;
            e.taken  = pt;
            e.target = ptgt;
            model_q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic pushPred(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        applyStimulus(1, pc, t, tgt, 0, 0, 0, 0, 1);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic ur);
        applyStimulus(0, 0, 0, 0, 1, pc, t, tgt, ur);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pred_ready"}, pred_ready, 1);
        checkOutput({tag, "_res_ready"}, res_ready, 1);
        checkOutput({tag, "_redirect_valid"}, redirect_valid, 0);
        checkOutput({tag, "_flush"}, flush, 0);
        checkOutput({tag, "_redirect_pc"}, redirect_pc, 0);
        checkOutput({tag, "_upd_valid"}, upd_valid, 0);
        checkOutput({tag, "_upd_idx"}, 32'(upd_idx), 0);
        checkOutput({tag, "_order_err"}, order_err, 0);
    endtask

    // Monitor: compares every presented output against the model and the expected-response queues.
    always @(negedge clk) begin : monitor
        upd_t u;
        if (mon_en && !reset) begin
            checkOutput("pred_ready", pred_ready, exp_pred_ready);
            checkOutput("res_ready", res_ready, exp_res_ready);
            checkOutput("redirect_valid", redirect_valid, m_flush);
            checkOutput("flush", flush, m_flush);
            if (redirect_valid && m_flush && exp_redir.size() > 0)
                checkOutput("redirect_pc", redirect_pc, exp_redir.pop_front());
            checkOutput("order_err", order_err, m_err_pulse);
            checkOutput("upd_valid", upd_valid, m_upd_pend);
            if (upd_valid && m_upd_pend && upd_ready && exp_upd.size() > 0) begin
                u = exp_upd.pop_front();
                checkOutput("upd_idx", 32'(upd_idx), 32'(u.idx));
                checkOutput("upd_taken", upd_taken, u.taken);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [31:0] ppc;
        logic [31:0] ptgt;
        logic [31:0] rpc;
        logic [31:0] rtgt;
        reset       = 1'b1;
        pred_valid  = 1'b0;
        pred_pc     = '0;
        pred_taken  = 1'b0;
        pred_target = '0;
        res_valid   = 1'b0;
        res_pc      = '0;
        res_taken   = 1'b0;
        res_target  = '0;
        upd_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset = 1'b0;

        $display("[TB] directed: correct not-taken prediction");
        pushPred(32'h100, 0, 32'h0);
        resolve(32'h100, 0, 32'h0, 1);
        idle(2);

        $display("[TB] directed: wrong target");
        pushPred(32'h200, 1, 32'h300);
        resolve(32'h200, 1, 32'h280, 1);
        idle(2);

        $display("[TB] directed: direction mispredict drops younger entries");
        pushPred(32'h10, 0, 32'h0);
        pushPred(32'h14, 0, 32'h0);
        pushPred(32'h18, 0, 32'h0);
        resolve(32'h10, 1, 32'h40, 1);
        idle(1);
        resolve(32'h14, 0, 32'h0, 1);
        idle(1);

        $display("[TB] directed: full FIFO");
        for (int i = 0; i < 5; i++) pushPred(32'h20 + 32'(i * 4), 0, 32'h0);
        resolve(32'h20, 0, 32'h0, 1);
        pushPred(32'h34, 0, 32'h0);
        for (int i = 1; i < 4; i++) resolve(32'h20 + 32'(i * 4), 0, 32'h0, 1);
        resolve(32'h34, 0, 32'h0, 1);
        idle(1);

        $display("[TB] directed: training port back-pressure");
        pushPred(32'h40, 0, 32'h0);
        pushPred(32'h44, 1, 32'h80);
        resolve(32'h40, 0, 32'h0, 0);
        resolve(32'h44, 1, 32'h80, 0);
        resolve(32'h44, 1, 32'h80, 0);
        resolve(32'h44, 1, 32'h80, 1);
        idle(2);

        $display("[TB] directed: ordering errors");
        resolve(32'h80, 0, 32'h0, 1);
        pushPred(32'h100, 0, 32'h0);
        resolve(32'h104, 0, 32'h0, 1);
        resolve(32'h100, 0, 32'h0, 1);
        idle(1);

        $display("[TB] directed: fall-through PC wraps");
        pushPred(32'hFFFF_FFFC, 1, 32'h8);
        resolve(32'hFFFF_FFFC, 0, 32'h0, 1);
        idle(2);

        $display("[TB] directed: push alongside mispredict");
        pushPred(32'h500, 0, 32'h0);
        applyStimulus(1, 32'h504, 0, 32'h0, 1, 32'h500, 1, 32'h600, 1);
        idle(1);
        resolve(32'h504, 0, 32'h0, 1);
        idle(1);

        $display("[TB] directed: reset during flush");
        pushPred(32'h200, 1, 32'h300);
        resolve(32'h200, 1, 32'h280, 1);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        checkResetValues("midflush");
        model_q.delete();
        exp_upd.delete();
        exp_redir.delete();
        m_flush     = 1'b0;
        m_upd_pend  = 1'b0;
        m_err_pulse = 1'b0;
        m_resolved  = 0;
        m_mispred   = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            ppc  = 32'h1000 + 32'($urandom_range(0, 63) << 2);
            ptgt = 32'h2000 + 32'($urandom_range(0, 3) << 2);
            if (model_q.size() > 0 && $urandom_range(0, 9) < 8) rpc = model_q[0].pc;
            else                                                 rpc = 32'h1000 + 32'($urandom_range(0, 63) << 2);
            if (model_q.size() > 0 && $urandom_range(0, 1) == 1) rtgt = model_q[0].target;
            else                                                  rtgt = 32'h2000 + 32'($urandom_range(0, 3) << 2);
            applyStimulus(1'($urandom_range(0, 1)), ppc, 1'($urandom_range(0, 1)), ptgt,
                          1'($urandom_range(0, 9) < 5), rpc, 1'($urandom_range(0, 1)), rtgt,
                          1'($urandom_range(0, 3) != 0));
        end

        idle(4);
        checkOutput("upd_queue_drained", 32'(exp_upd.size()), 0);
        checkOutput("redirect_queue_drained", 32'(exp_redir.size()), 0);
`ifdef BRU_PERF_CNT_EN
        checkOutput("perf_resolved", perf_resolved, m_resolved);
        checkOutput("perf_mispred", perf_mispred, m_mispred);
`endif
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
